// File: rtl/router_pkg.sv
// Shared router types: flit layout, pipeline bus, output-port FSM states and constants.
package router_pkg;

    localparam int NUM_OF_PORTS    = 5;
    localparam int OUT_BUF_CREDITS = 4;
    localparam int FLIT_DATA_W     = 16;
    localparam int FLIT_DEST_W     = 4;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } FLIT_TYPE;

    typedef struct packed {
        FLIT_TYPE               flit_type;
        logic [FLIT_DEST_W-1:0] dest;
    } flit_head_t;

    typedef struct packed {
        flit_head_t             head;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    typedef struct packed {
        flit_t flit;
    } router_pipeline_bus_t;

    typedef enum logic {
        OP_IDLE,
        OP_LOCKED
    } OP_STATE;

endpackage

// File: rtl/output_port_unit_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after i_ptr,
// wrapping to the lowest index when nothing at or above the pointer is requesting.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic [N-1:0] w_hi;
    logic [N-1:0] w_lo;

    // Scanning downward leaves the lowest qualifying index in each candidate.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_lo = N'(1) << j;
                if (PW'(j) >= i_ptr) begin
                    w_hi = N'(1) << j;
                end
            end
        end
    end

    assign o_grant = (w_hi != '0) ? w_hi : w_lo;

endmodule

// File: rtl/output_port_unit.sv
// Router output port: round-robin grant with wormhole lock, credit-gated flit register toward the link.
// OP_IDLE: no owner, arbitrating i_req | OP_LOCKED: owner holds the port until its tail flit is accepted.
module output_port_unit
    import router_pkg::*;
#(
    parameter  int BUF_CREDITS = OUT_BUF_CREDITS,
    localparam int CREDIT_W    = $clog2(BUF_CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_OF_PORTS-1:0]   i_req,
    output logic [NUM_OF_PORTS-1:0]   o_ack,
    input  logic                      i_flit_valid,
    input  router_pipeline_bus_t      i_flit,
    output logic                      o_ready,
    output logic                      o_flit_valid,
    output router_pipeline_bus_t      o_flit,
    input  logic                      i_credit_ret,
    output logic [CREDIT_W-1:0]       o_credits,
    output logic [NUM_OF_PORTS-1:0]   o_owner,
    output logic [1:0]                o_err
);

    localparam int PW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;
    localparam logic [CREDIT_W-1:0] CREDITS_MAX = CREDIT_W'(BUF_CREDITS);

    OP_STATE                 r_state;
    logic [NUM_OF_PORTS-1:0] r_owner;
    logic [PW-1:0]           r_rr_ptr;
    logic [CREDIT_W-1:0]     r_credits;
    logic                    r_flit_valid;
    router_pipeline_bus_t    r_flit;
    logic [1:0]              r_err;

    logic [NUM_OF_PORTS-1:0] w_grant;
    logic [NUM_OF_PORTS-1:0] w_ack;
    logic                    w_has_credit;
    logic                    w_accept;
    logic                    w_tail;
    logic [PW-1:0]           w_owner_idx;
    logic [PW-1:0]           w_next_ptr;

    rr_arbiter #(.N(NUM_OF_PORTS)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    assign w_has_credit = (r_credits != '0);
    assign w_accept     = i_flit_valid && w_has_credit && (r_state == OP_LOCKED);
    assign w_tail       = (i_flit.flit.head.flit_type == TAIL_FLIT);

    // While locked the switch sees the owner regardless of i_req, so its mux select stays stable.
    assign w_ack = (r_state == OP_LOCKED) ? r_owner :
                   (w_has_credit ? w_grant : '0);

    always_comb begin
        w_owner_idx = '0;
        for (int j = 0; j < NUM_OF_PORTS; j++) begin
            if (r_owner[j]) begin
                w_owner_idx = PW'(j);
            end
        end
    end

    assign w_next_ptr = (w_owner_idx == PW'(NUM_OF_PORTS - 1)) ? '0 : w_owner_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= OP_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_credits    <= CREDITS_MAX;
            r_flit_valid <= 1'b0;
            r_flit       <= '0;
            r_err        <= '0;
        end else begin
            r_flit_valid <= w_accept;
            if (w_accept) begin
                r_flit <= i_flit;
            end

            case (r_state)
                OP_IDLE: begin
                    if (i_flit_valid) begin
                        r_err[0] <= 1'b1;
                    end
                    if (w_ack != '0) begin
                        r_owner <= w_ack;
                        r_state <= OP_LOCKED;
                    end
                end
                OP_LOCKED: begin
                    if (w_accept && w_tail) begin
                        r_state  <= OP_IDLE;
                        r_owner  <= '0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= OP_IDLE;
            endcase

            // A simultaneous accept and return cancel out.
            case ({w_accept, i_credit_ret})
                2'b10: r_credits <= r_credits - CREDIT_W'(1);
                2'b01: begin
                    if (r_credits == CREDITS_MAX) begin
                        r_err[1] <= 1'b1;
                    end else begin
                        r_credits <= r_credits + CREDIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ack        = w_ack;
    assign o_ready      = w_has_credit;
    assign o_flit_valid = r_flit_valid;
    assign o_flit       = r_flit;
    assign o_credits    = r_credits;
    assign o_owner      = r_owner;
    assign o_err        = r_err;

endmodule

// File: tb/tb_output_port_unit.sv
// Directed bench for output_port_unit: a 4-credit and a 2-credit instance share stimulus;
// accepted flits are queued when driven and compared when they appear on the link side.
module tb_output_port_unit;
    import router_pkg::*;

    logic                    clk;
    logic                    rst;
    logic [NUM_OF_PORTS-1:0] i_req;
    logic                    i_flit_valid;
    router_pipeline_bus_t    i_flit;
    logic                    i_credit_ret;

    logic [NUM_OF_PORTS-1:0] ack_a, owner_a, ack_b, owner_b;
    logic                    ready_a, fv_a, ready_b, fv_b;
    router_pipeline_bus_t    flit_a, flit_b;
    logic [2:0]              credits_a;
    logic [1:0]              credits_b;
    logic [1:0]              err_a, err_b;

    int checks   = 0;
    int failures = 0;
    logic sel = 1'b0;
    router_pipeline_bus_t exp_q[$];

    output_port_unit #(.BUF_CREDITS(4)) dut_a (
        .clk(clk), .rst(rst), .i_req(i_req), .o_ack(ack_a),
        .i_flit_valid(i_flit_valid), .i_flit(i_flit), .o_ready(ready_a),
        .o_flit_valid(fv_a), .o_flit(flit_a), .i_credit_ret(i_credit_ret),
        .o_credits(credits_a), .o_owner(owner_a), .o_err(err_a)
    );

    output_port_unit #(.BUF_CREDITS(2)) dut_b (
        .clk(clk), .rst(rst), .i_req(i_req), .o_ack(ack_b),
        .i_flit_valid(i_flit_valid), .i_flit(i_flit), .o_ready(ready_b),
        .o_flit_valid(fv_b), .o_flit(flit_b), .i_credit_ret(i_credit_ret),
        .o_credits(credits_b), .o_owner(owner_b), .o_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic router_pipeline_bus_t mk(input FLIT_TYPE t, input logic [15:0] d);
        router_pipeline_bus_t f;
        f = '0;
        f.flit.head.flit_type = t;
        f.flit.head.dest      = 4'h3;
        f.flit.data           = d;
        return f;
    endfunction

    task automatic check_out();
        router_pipeline_bus_t e;
        logic                 v;
        router_pipeline_bus_t f;
        v = sel ? fv_b : fv_a;
        f = sel ? flit_b : flit_a;
        chk(32'(v), (exp_q.size() != 0) ? 32'd1 : 32'd0, "flit_valid");
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(32'(f), 32'(e), "flit_data");
        end
    endtask

    task automatic send(input FLIT_TYPE t, input logic [15:0] d, input logic acc);
        i_flit       = mk(t, d);
        i_flit_valid = 1'b1;
        if (acc) exp_q.push_back(i_flit);
        tick();
        check_out();
    endtask

    initial begin
        rst = 1'b1; i_req = '0; i_flit_valid = 1'b0; i_flit = '0; i_credit_ret = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk(32'(ack_a), 32'd0, "rst_ack");
        chk(32'(owner_a), 32'd0, "rst_owner");
        chk(32'(credits_a), 32'd4, "rst_credits");
        chk(32'(fv_a), 32'd0, "rst_flit_valid");
        chk(32'(err_a), 32'd0, "rst_err");
        chk(32'(ready_a), 32'd1, "rst_ready");
        chk(32'(credits_b), 32'd2, "rst_credits_b");

        // Grant to input 2, then lock independent of i_req
        i_req = 5'b00100; #1;
        chk(32'(ack_a), 32'b00100, "grant_comb");
        tick();
        i_req = 5'b00000; #1;
        chk(32'(owner_a), 32'b00100, "owner_locked");
        chk(32'(ack_a), 32'b00100, "ack_held");
        send(TAIL_FLIT, 16'hA000, 1'b1);
        i_flit_valid = 1'b0; i_credit_ret = 1'b1;
        tick();
        i_credit_ret = 1'b0;
        check_out();
        chk(32'(credits_a), 32'd4, "credit_restore");

        // Packet from input 0 (pointer is 3, wraps to 0)
        i_req = 5'b00001; #1;
        chk(32'(ack_a), 32'b00001, "grant_wrap");
        tick();
        i_req = 5'b00000;
        send(HEAD_FLIT, 16'h1111, 1'b1);
        send(BODY_FLIT, 16'h2222, 1'b1);
        send(TAIL_FLIT, 16'h3333, 1'b1);
        chk(32'(credits_a), 32'd1, "credits_after_pkt");
        chk(32'(owner_a), 32'd0, "idle_after_tail");
        i_flit_valid = 1'b0;
        tick();
        check_out();
        i_credit_ret = 1'b1;
        tick(); tick(); tick();
        i_credit_ret = 1'b0;
        chk(32'(credits_a), 32'd4, "credits_refill");

        // Pointer 1 with requests 0 and 4 -> 4 first, then 0
        i_req = 5'b10001; #1;
        chk(32'(ack_a), 32'b10000, "rr_pick_4");
        tick();
        chk(32'(owner_a), 32'b10000, "owner_4");
        send(TAIL_FLIT, 16'h4444, 1'b1);
        chk(32'(ack_a), 32'b00001, "rr_next_0");
        i_flit_valid = 1'b0; i_req = '0;

        // Two-credit instance: tail stalls until a credit returns
        rst = 1'b1; tick(); rst = 1'b0;
        sel = 1'b1;
        i_req = 5'b00001;
        tick();
        i_req = '0;
        send(HEAD_FLIT, 16'h5555, 1'b1);
        send(BODY_FLIT, 16'h6666, 1'b1);
        chk(32'(credits_b), 32'd0, "credits_b_empty");
        chk(32'(ready_b), 32'd0, "ready_b_low");
        send(TAIL_FLIT, 16'h7777, 1'b0);
        i_credit_ret = 1'b1;
        send(TAIL_FLIT, 16'h7777, 1'b0);
        i_credit_ret = 1'b0;
        chk(32'(ready_b), 32'd1, "ready_b_back");
        send(TAIL_FLIT, 16'h7777, 1'b1);
        chk(32'(owner_b), 32'd0, "owner_b_released");
        chk(32'(credits_b), 32'd0, "credits_b_after_tail");
        i_flit_valid = 1'b0;

        // Credit overflow and flit while idle
        rst = 1'b1; tick(); rst = 1'b0;
        sel = 1'b0;
        i_credit_ret = 1'b1;
        tick();
        i_credit_ret = 1'b0;
        chk(32'(credits_a), 32'd4, "credit_saturate");
        chk(32'(err_a), 32'b10, "err_overflow");
        send(BODY_FLIT, 16'h8888, 1'b0);
        chk(32'(err_a), 32'b11, "err_idle_flit");
        i_flit_valid = 1'b0;

        // Reset in the middle of a packet
        rst = 1'b1; tick(); rst = 1'b0;
        i_req = 5'b00010;
        tick();
        i_req = '0;
        send(HEAD_FLIT, 16'h9999, 1'b1);
        i_flit = mk(BODY_FLIT, 16'hAAAA);
        rst = 1'b1;
        tick();
        rst = 1'b0; i_flit_valid = 1'b0;
        chk(32'(fv_a), 32'd0, "midrst_flit_valid");
        chk(32'(credits_a), 32'd4, "midrst_credits");
        chk(32'(err_a), 32'd0, "midrst_err");
        chk(32'(owner_a), 32'd0, "midrst_owner");
        chk(32'(ack_a), 32'd0, "midrst_ack");
        chk(32'(exp_q.size()), 32'd0, "queue_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
